muldiv_ctrl: RTL
================

# muldiv_ctrl

Sequencer and owner of the HI/LO register pair for the EX stage. It accepts multiply, divide and HI/LO-move requests from the ALU decode. It runs signed or unsigned 32x32 multiplies in a fixed two-cycle internal schedule, and drives the shared iterative divider through a start/ready/annul handshake. It stalls the pipeline until results commit, and discards an in-flight operation on an exception flush without touching HI/LO.

## Interface
Parameters: none. Opcode encoding of `req_op` is fixed:
- 000 NONE
- 001 MULT
- 010 MULTU
- 011 DIV
- 100 DIVU
- 101 MTHI
- 110 MTLO
- 111 NONE

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: EX-stage instruction valid. Held stable by the pipeline while `stall_o`=1.
- `req_op` in 3: operation, encoding above.
- `req_a` in 32: rs operand (dividend / multiplicand / MTHI, MTLO source).
- `req_b` in 32: rt operand (divisor / multiplier).
- `flush` in 1: exception or annul of the EX-stage instruction.
- `stall_o` out 1: pipeline stall request.
- `hi_o` out 32: committed HI register.
- `lo_o` out 32: committed LO register.
- `busy_o` out 1: state != IDLE.
- `div_start` out 1: divider start, level.
- `div_signed` out 1: 1 for DIV, 0 for DIVU.
- `div_a` out 32: latched dividend.
- `div_b` out 32: latched divisor.
- `div_annul` out 1: one-cycle abort pulse to the divider.
- `div_result` in 64: {remainder, quotient}.
- `div_ready` in 1: divider result valid, one-cycle pulse.

## Operation
- State machine: IDLE, MUL, DIV, DONE.
- IDLE accepts a request when `req_valid`=1 and `flush`=0. Any other case is ignored.
  - MTHI: HI <= `req_a` at the clock edge. No stall, stays IDLE.
  - MTLO: LO <= `req_a` at the clock edge. No stall, stays IDLE.
  - MULT, MULTU: latch a, b and signedness; go to MUL.
  - DIV, DIVU: latch a, b and `div_signed`; go to DIV.
- MUL: compute the 64-bit product from the latched operands.
  - MULT uses $signed × $signed; MULTU is zero-extended.
  - {HI, LO} <= product at the end of the cycle; go to DONE.
- DIV: `div_start`=1 continuously. When `div_ready`=1, HI <= `div_result`[63:32] and LO <= `div_result`[31:0]; go to DONE.
- Divide by zero: HI/LO take whatever the divider returns. No trap, no special case.
- DONE: `stall_o`=0 so the instruction leaves EX this cycle. The request still presented is the same instruction and is NOT re-accepted. Always go to IDLE.
- `stall_o` is combinational = (state==MUL) | (state==DIV) | (state==IDLE & `req_valid` & ~`flush` & op ∈ {MULT, MULTU, DIV, DIVU}).
- `flush`=1 in MUL or DIV: go to IDLE, HI/LO unchanged, `stall_o`=0 that cycle.
  - In DIV, `div_annul`=1 for that one cycle and `div_start`=0.
  - A `div_ready` arriving in the same cycle as `flush` is discarded.
- `flush` in DONE: HI/LO are already committed and not rolled back; go to IDLE.
- Reset (asynchronous, mid-operation included): state=IDLE, HI=LO=0, and all of `stall_o`, `div_start`, `div_signed`, `div_annul` = 0. `div_a` and `div_b` are 0.

## Timing
- MTHI/MTLO: zero stall. New value visible on `hi_o`/`lo_o` the cycle after acceptance.
- MULT/MULTU: accept cycle T. `stall_o`=1 in T and T+1. HI/LO updated at the end of T+1. DONE at T+2 with `stall_o`=0. Three cycles in EX.
- DIV/DIVU: accept T, `div_start` rises at T+1. `div_ready` arrives in cycle R; HI/LO are written at the end of R. DONE at R+1. `stall_o`=1 from T through R inclusive.
- `hi_o`/`lo_o` are register outputs. There is no bypass of in-flight results.
- Back-to-back MULT then DIV: the second request is accepted in the IDLE cycle following DONE. The minimum gap between acceptances is three cycles.

## Test plan
- Reset: assert `rst`=0 mid-DIV, with `div_start` high. Required: `div_start`=0, `stall_o`=0, `hi_o`=`lo_o`=0 immediately, with no clock edge needed.
- MULT signed: a=0xFFFFFFFE (-2), b=0x00000003. Required: `stall_o`=1 for 2 cycles, then `hi_o`=0xFFFFFFFF and `lo_o`=0xFFFFFFFA. Under MULTU, the same operands give `hi_o`=0x00000002 and `lo_o`=0xFFFFFFFA.
- DIV with a model divider ready after 5 cycles: a=0xFFFFFFF9 (-7), b=2. Required: `div_signed`=1, `div_start` held until ready, `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFFD, `stall_o` drops exactly in the DONE cycle.
- Flush during DIV in its 3rd cycle. Required: a single-cycle `div_annul`, `stall_o`=0 that cycle, HI/LO keep the prior values 0x11111111/0x22222222, and a late `div_ready` is ignored.
- MTHI 0xDEADBEEF then immediately MTLO 0x12345678 with no stall. Required: `hi_o`=0xDEADBEEF and `lo_o`=0x12345678, `stall_o` never asserted.
- MULTU held through DONE, then a new DIVU. Required: exactly one multiply commit, and the DIVU is accepted in the following IDLE cycle.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// EX-stage multiply/divide bundle: pipeline request side, HI/LO results and
// the handshake to the shared iterative divider.
interface muldiv_ctrl_if;
    localparam int unsigned XLEN = 32;

    logic              req_valid;
    logic [2:0]        req_op;
    logic [XLEN-1:0]   req_a;
    logic [XLEN-1:0]   req_b;
    logic              flush;
    logic              stall_o;
    logic [XLEN-1:0]   hi_o;
    logic [XLEN-1:0]   lo_o;
    logic              busy_o;
    logic              div_start;
    logic              div_signed;
    logic [XLEN-1:0]   div_a;
    logic [XLEN-1:0]   div_b;
    logic              div_annul;
    logic [2*XLEN-1:0] div_result;
    logic              div_ready;

    modport master (
        output req_valid, req_op, req_a, req_b, flush, div_result, div_ready,
        input  stall_o, hi_o, lo_o, busy_o, div_start, div_signed, div_a, div_b, div_annul
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush, div_result, div_ready,
        output stall_o, hi_o, lo_o, busy_o, div_start, div_signed, div_a, div_b, div_annul
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and mult/div sequencer for EX: two-cycle multiply, divider
// handshake, pipeline stall and flush discard.
module muldiv_ctrl (
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
);
    localparam int unsigned XLEN = 32;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   op_a_q;
    logic [XLEN-1:0]   op_b_q;
    logic              mul_signed_q;
    logic              div_signed_q;
    logic              accept;
    logic              is_mul;
    logic              is_div;
    logic [2*XLEN-1:0] mul_a_ext;
    logic [2*XLEN-1:0] mul_b_ext;
    logic [2*XLEN-1:0] product;

    assign accept = (state_q == IDLE) & bus.req_valid & ~bus.flush;
    assign is_mul = (bus.req_op == OP_MULT) | (bus.req_op == OP_MULTU);
    assign is_div = (bus.req_op == OP_DIV)  | (bus.req_op == OP_DIVU);

    // Sign-extend to 64 bits so one unsigned multiplier serves MULT and MULTU
    assign mul_a_ext = {{XLEN{mul_signed_q & op_a_q[XLEN-1]}}, op_a_q};
    assign mul_b_ext = {{XLEN{mul_signed_q & op_b_q[XLEN-1]}}, op_b_q};
    assign product   = mul_a_ext * mul_b_ext;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    state_d = MUL;
                end else if (accept && is_div) begin
                    state_d = DIV;
                end
            end
            MUL:  state_d = bus.flush ? IDLE : DONE;
            DIV: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.div_ready) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // HI/LO commit and operand latches; a flush suppresses every commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q         <= '0;
            lo_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            mul_signed_q <= 1'b0;
            div_signed_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && (bus.req_op == OP_MTHI)) begin
                        hi_q <= bus.req_a;
                    end
                    if (accept && (bus.req_op == OP_MTLO)) begin
                        lo_q <= bus.req_a;
                    end
                    if (accept && (is_mul || is_div)) begin
                        op_a_q <= bus.req_a;
                        op_b_q <= bus.req_b;
                    end
                    if (accept && is_mul) begin
                        mul_signed_q <= (bus.req_op == OP_MULT);
                    end
                    if (accept && is_div) begin
                        div_signed_q <= (bus.req_op == OP_DIV);
                    end
                end
                MUL: begin
                    if (!bus.flush) begin
                        hi_q <= product[2*XLEN-1:XLEN];
                        lo_q <= product[XLEN-1:0];
                    end
                end
                DIV: begin
                    if (!bus.flush && bus.div_ready) begin
                        hi_q <= bus.div_result[2*XLEN-1:XLEN];
                        lo_q <= bus.div_result[XLEN-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Stall is combinational so the accept cycle itself holds the pipeline
    assign bus.stall_o    = rst & ((accept & (is_mul | is_div)) |
                                   (((state_q == MUL) | (state_q == DIV)) & ~bus.flush));
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;
    assign bus.div_start  = (state_q == DIV) & ~bus.flush;
    assign bus.div_annul  = (state_q == DIV) & bus.flush;
    assign bus.div_signed = div_signed_q;
    assign bus.div_a      = op_a_q;
    assign bus.div_b      = op_b_q;
endmodule
